// File: rtl/mem_copy_dma.sv
// mem_copy_dma: second bus master on the tiny16 memory port.
// Copies a block of words from src to dst, one word at a time, ascending.
// Each word takes four cycles: latch read address, read, latch write address, write.
module mem_copy_dma #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_addr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_in_en,
    output logic [DATA_WIDTH-1:0] mem_in,
    output logic                  mem_out_en,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_READ,
        S_WADDR,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   src_ptr, dst_ptr, count;
    logic [DATA_WIDTH-1:0]   buffer;

    // Write data is the captured word; it naturally holds its value between writes.
    assign mem_in = buffer;

    // State register; enables are decoded from state so reset drops them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Pointer, count and data-capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            buffer  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        count   <= len;
                    end
                end
                S_WADDR: buffer <= mem_out;
                S_WRITE: begin
                    src_ptr <= src_ptr + ONE;
                    dst_ptr <= dst_ptr + ONE;
                    count   <= count - ONE;
                end
                default: ;
            endcase
        end
    end

    // Next-state and bus-output decode; at most one enable per state.
    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_addr_en = 1'b0;
        mem_out_en  = 1'b0;
        mem_in_en   = 1'b0;
        mem_addr    = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = (len == '0) ? S_DONE : S_RADDR;
            end
            S_RADDR: begin
                busy        = 1'b1;
                mem_addr_en = 1'b1;
                mem_addr    = src_ptr;
                state_nx    = S_READ;
            end
            S_READ: begin
                busy       = 1'b1;
                mem_out_en = 1'b1;
                state_nx   = S_WADDR;
            end
            S_WADDR: begin
                busy        = 1'b1;
                mem_addr_en = 1'b1;
                mem_addr    = dst_ptr;
                state_nx    = S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_in_en = 1'b1;
                state_nx  = (count == ONE) ? S_DONE : S_RADDR;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behavioural tiny16 memory, reference copy model
// feeding an expected-write scoreboard, and a monitor on the write strobe.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src, dst, len;
    logic        busy, done;
    logic        mem_addr_en, mem_in_en, mem_out_en;
    logic [15:0] mem_addr, mem_in, mem_out;

    mem_copy_dma #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done),
        .mem_addr_en(mem_addr_en), .mem_addr(mem_addr),
        .mem_in_en(mem_in_en), .mem_in(mem_in),
        .mem_out_en(mem_out_en), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // Behavioural memory: address latch, registered read, write on in_en.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] addr_lat = 16'h0;

    always @(posedge clk) begin
        if (mem_in_en) mem[addr_lat] = mem_in;
        if (mem_out_en) mem_out <= mem[addr_lat];
        if (mem_addr_en) addr_lat <= mem_addr;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT write is popped against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_addr_en || mem_in_en || mem_out_en) begin
                en_cnt++;
                chk("onehot_en", 32'($countones({mem_addr_en, mem_in_en, mem_out_en})), 1);
            end
            if (mem_in_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {addr_lat, mem_in}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", addr_lat, e.a);
                    chk("wr_data", mem_in, e.d);
                end
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Issue one start; the model performs the first npush words of the copy.
    task automatic do_start(input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input int npush);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        for (int i = 0; i < npush; i++) begin
            logic [15:0] sa, da;
            sa = s + 16'(i);
            da = d + 16'(i);
            ref_mem[da] = ref_mem[sa];
            exp_q.push_back('{da, ref_mem[da]});
        end
        @(negedge clk);
        start = 1'b0;
        src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
    endtask

    // Called at the negedge of cycle 1 after accept; returns done cycle and width.
    task automatic wait_done(input int budget, output int cyc, output int width,
                             output bit busy_seen);
        cyc = 0; width = 0; busy_seen = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (busy) busy_seen = 1'b1;
            if (done) begin
                width++;
                if (cyc == 0) cyc = k;
            end else if (cyc != 0) begin
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, width, en0, dcount, bad;
        bit busy_seen;
        logic [15:0] s, d, l, keep;

        for (int i = 0; i < 65536; i++) begin
            keep = 16'($urandom);
            mem[i] = keep;
            ref_mem[i] = keep;
        end
        start = 1'b0; src = '0; dst = '0; len = '0;

        // 1: reset state and quiet idle
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", {mem_addr_en, mem_in_en, mem_out_en}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_mem_in", mem_in, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_en", en_cnt, 0);

        // 2: basic copy
        preload(16'h0000, 16'h1234);
        preload(16'h0001, 16'h4321);
        do_start(16'h0000, 16'h0100, 16'd2, 2);
        wait_done(30, cyc, width, busy_seen);
        chk("basic_done_cyc", cyc, 9);
        chk("basic_done_w", width, 1);
        chk("basic_m100", mem[16'h0100], 16'h1234);
        chk("basic_m101", mem[16'h0101], 16'h4321);

        // 3: zero length
        keep = mem[16'h0006];
        en0 = en_cnt;
        do_start(16'h0005, 16'h0006, 16'd0, 0);
        wait_done(10, cyc, width, busy_seen);
        chk("len0_done_cyc", cyc, 1);
        chk("len0_done_w", width, 1);
        chk("len0_busy", busy_seen, 0);
        chk("len0_no_en", en_cnt - en0, 0);
        chk("len0_mem", mem[16'h0006], keep);

        // 4: source pointer wraps past 0xFFFF
        preload(16'hFFFF, 16'hAAAA);
        preload(16'h0000, 16'h5555);
        do_start(16'hFFFF, 16'h0200, 16'd2, 2);
        wait_done(30, cyc, width, busy_seen);
        chk("wrap_done_cyc", cyc, 9);
        chk("wrap_m200", mem[16'h0200], 16'hAAAA);
        chk("wrap_m201", mem[16'h0201], 16'h5555);

        // 5: overlapping ascending copy, second start ignored
        preload(16'h0010, 16'hBEEF);
        do_start(16'h0010, 16'h0011, 16'd3, 3);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; src = 16'h0050; dst = 16'h0060; len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("ovl_one_done", dcount, 1);
        chk("ovl_m11", mem[16'h0011], 16'hBEEF);
        chk("ovl_m12", mem[16'h0012], 16'hBEEF);
        chk("ovl_m13", mem[16'h0013], 16'hBEEF);

        // 6: reset mid-copy in cycle 6 (first word already written in cycle 4)
        do_start(16'h0300, 16'h0400, 16'd4, 1);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_en", {mem_addr_en, mem_in_en, mem_out_en}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_q", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        en0 = en_cnt;
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("midrst_no_done", dcount, 0);
        chk("midrst_no_en", en_cnt - en0, 0);

        // Random copies anywhere in the address space
        for (int t = 0; t < 12; t++) begin
            s = 16'($urandom);
            d = (t % 3 == 0) ? s + 16'($urandom_range(1, 3)) : 16'($urandom);
            l = 16'($urandom_range(0, 6));
            do_start(s, d, l, int'(l));
            wait_done(4 * int'(l) + 10, cyc, width, busy_seen);
            chk("rand_done_cyc", cyc, 4 * int'(l) + 1);
            chk("rand_done_w", width, 1);
            chk("rand_q_empty", exp_q.size(), 0);
            @(negedge clk);
        end

        bad = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
